// File: rtl/psi_pkg.sv
// rtl/psi_pkg.sv - shared types and sizing helpers for the PSI set encoder
package psi_pkg;

  localparam int B_DEFAULT = 10;
  localparam int N_DEFAULT = 4;

  // Element index width; a universe of one element still needs a 1-bit index port
  function automatic int idx_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_t;

endpackage

// File: rtl/psi_bitmap_acc.sv
// rtl/psi_bitmap_acc.sv - one-hot element decode and per-party bitmap accumulator
module psi_bitmap_acc
  import psi_pkg::*;
#(
  parameter  int B  = B_DEFAULT,
  localparam int IW = idx_width(B)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          set_en,
  input  logic [IW-1:0] elem,
  output logic [B-1:0]  bitmap
);

  logic [B-1:0] cur;
  logic [B-1:0] hit;

  // Only indices below B have a decode line, so out-of-range elements set nothing
  for (genvar k = 0; k < B; k++) begin : g_dec
    assign hit[k] = set_en && (elem == IW'(k));
  end

  // bitmap already includes this cycle's beat so the closing beat lands in the slot
  assign bitmap = cur | hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= '0;
    end else if (clr) begin
      cur <= '0;
    end else if (set_en) begin
      cur <= bitmap;
    end
  end

endmodule

// File: rtl/psi_set_encoder.sv
// rtl/psi_set_encoder.sv - packs n per-party membership bitmaps for the PSI stage
// Optional sticky out-of-range flag on err when PSI_RANGE_CHECK_EN is defined.
module psi_set_encoder
  import psi_pkg::*;
#(
  parameter  int b  = B_DEFAULT,
  parameter  int n  = N_DEFAULT,
  localparam int IW = idx_width(b),
  localparam int PW = $clog2(n)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IW-1:0]   in_elem,
  input  logic            in_null,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [n*b-1:0]  all_input,
  output logic            err
);

  state_t        state;
  state_t        state_next;
  logic [PW-1:0] party_idx;
  logic [b-1:0]  party_bitmap;
  logic          accept;
  logic          set_en;
  logic          close;
  logic          last_party;
  logic          drain;

  assign in_ready   = (state == COLLECT);
  assign out_valid  = (state == FULL);
  assign accept     = in_valid && in_ready;
  assign set_en     = accept && !in_null;
  assign close      = accept && in_last;
  assign last_party = (party_idx == PW'(n - 1));
  assign drain      = (state == FULL) && out_ready;

  psi_bitmap_acc #(.B(b)) u_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (close),
    .set_en (set_en),
    .elem   (in_elem),
    .bitmap (party_bitmap)
  );

  always_comb begin
    state_next = state;
    case (state)
      COLLECT: if (close && last_party) state_next = FULL;
      FULL:    if (out_ready)           state_next = COLLECT;
      default:                          state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= COLLECT;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      party_idx <= '0;
    end else if (close) begin
      party_idx <= last_party ? '0 : party_idx + 1'b1;
    end
  end

  // close only happens in COLLECT and drain only in FULL, so they never collide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      all_input <= '0;
    end else if (close) begin
      for (int i = 0; i < n; i++) begin
        if (party_idx == PW'(i)) begin
          all_input[i*b +: b] <= party_bitmap;
        end
      end
    end else if (drain) begin
      all_input <= '0;
    end
  end

`ifdef PSI_RANGE_CHECK_EN
  localparam logic [IW:0] B_LIMIT = (IW + 1)'(b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (set_en && ({1'b0, in_elem} >= B_LIMIT)) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_psi_set_encoder.sv
// tb/tb_psi_set_encoder.sv - directed and randomized checks of psi_set_encoder (b=10, n=4)
module tb_psi_set_encoder;

  localparam int B  = 10;
  localparam int N  = 4;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_elem;
  logic          in_null;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [N*B-1:0] all_input;
  logic          err;

  int passed = 0;
  int total  = 0;
  bit err_en;
  bit exp_err;
  logic [B-1:0] mdl [N];
  logic [N*B-1:0] held;

  psi_set_encoder #(.b(B), .n(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_elem   (in_elem),
    .in_null   (in_null),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .all_input (all_input),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic [N*B-1:0] pack(input logic [B-1:0] s0, input logic [B-1:0] s1,
                                          input logic [B-1:0] s2, input logic [B-1:0] s3);
    return {s3, s2, s1, s0};
  endfunction

  // Inputs change 1 time unit after a rising edge; the next edge samples them
  task automatic beat(input int e, input bit nul, input bit last);
    in_valid = 1'b1;
    in_elem  = e[IW-1:0];
    in_null  = nul;
    in_last  = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_null  = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_drain_data"}, 64'(all_input), 64'h0);
    check({tag, "_drain_ready"}, 64'(in_ready), 64'h1);
  endtask

  task automatic party_set(input int a, input int c);
    beat(a, 1'b0, 1'b0);
    beat(c, 1'b0, 1'b1);
  endtask

  initial begin
`ifdef PSI_RANGE_CHECK_EN
    err_en = 1'b1;
`else
    err_en = 1'b0;
`endif
    exp_err   = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_elem   = '0;
    in_null   = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(in_ready), 64'h1);
    check("rst_valid", 64'(out_valid), 64'h0);
    check("rst_data", 64'(all_input), 64'h0);
    check("rst_err", 64'(err), 64'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: four parties, out_valid one cycle after the final beat
    party_set(1, 3);
    party_set(3, 5);
    beat(3, 1'b0, 1'b1);
    beat(3, 1'b0, 1'b0);
    check("t1_not_yet_valid", 64'(out_valid), 64'h0);
    beat(9, 1'b0, 1'b1);
    check("t1_valid", 64'(out_valid), 64'h1);
    check("t1_ready_low", 64'(in_ready), 64'h0);
    check("t1_data", 64'(all_input), 64'(pack(10'h00A, 10'h028, 10'h008, 10'h208)));

    // 2: backpressure holds the word; beats offered in FULL must be ignored
    held = all_input;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_elem  = 4'd0;
      in_last  = 1'b1;
      @(posedge clk); #1;
      check("t2_ready_low", 64'(in_ready), 64'h0);
      check("t2_stable", 64'(all_input), 64'(held));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    consume("t2");
    check("t2_valid_low", 64'(out_valid), 64'h0);

    // 3: duplicates are idempotent, a lone null+last closes an empty party
    beat(0, 1'b0, 1'b1);
    beat(7, 1'b0, 1'b0);
    beat(7, 1'b0, 1'b0);
    beat(7, 1'b0, 1'b1);
    beat(5, 1'b1, 1'b1);
    beat(2, 1'b1, 1'b0);
    beat(2, 1'b0, 1'b1);
    check("t3_valid", 64'(out_valid), 64'h1);
    check("t3_data", 64'(all_input), 64'(pack(10'h001, 10'h080, 10'h000, 10'h004)));
    consume("t3");

    // 4: out-of-range element sets no bit
    beat(12, 1'b0, 1'b0);
    exp_err = err_en;
    beat(4, 1'b0, 1'b1);
    check("t4_err", 64'(err), 64'(exp_err));
    beat(0, 1'b1, 1'b1);
    beat(0, 1'b1, 1'b1);
    beat(15, 1'b0, 1'b1);
    check("t4_data", 64'(all_input), 64'(pack(10'h010, 10'h000, 10'h000, 10'h000)));
    consume("t4");
    check("t4_err_sticky", 64'(err), 64'(exp_err));

    // 5: asynchronous reset mid-stream discards the two completed parties
    party_set(2, 6);
    party_set(8, 0);
    beat(5, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_async_data", 64'(all_input), 64'h0);
    check("t5_async_valid", 64'(out_valid), 64'h0);
    check("t5_async_ready", 64'(in_ready), 64'h1);
    check("t5_async_err", 64'(err), 64'h0);
    exp_err = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    beat(1, 1'b0, 1'b1);
    beat(2, 1'b0, 1'b1);
    beat(3, 1'b0, 1'b1);
    beat(4, 1'b0, 1'b1);
    check("t5_refill", 64'(all_input), 64'(pack(10'h002, 10'h004, 10'h008, 10'h010)));
    consume("t5");

    // 6: random gaps, nulls and out-of-range indices against a set model
    for (int round = 0; round < 2; round++) begin
      for (int p = 0; p < N; p++) begin
        mdl[p] = '0;
        for (int j = 0; j < 10; j++) begin
          int e;
          bit nul;
          int idle;
          idle = $urandom_range(0, 2);
          for (int k = 0; k < idle; k++) begin
            in_valid = 1'b0;
            in_elem  = 4'($urandom_range(0, 15));
            in_last  = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
          end
          in_last = 1'b0;
          e   = $urandom_range(0, 15);
          nul = ($urandom_range(0, 5) == 0);
          if (!nul && e < B) mdl[p][e] = 1'b1;
          if (!nul && e >= B) exp_err = exp_err | err_en;
          if (p == N - 1 && j == 9) begin
            check("t6_pre_valid", 64'(out_valid), 64'h0);
          end
          beat(e, nul, j == 9);
        end
      end
      check("t6_valid", 64'(out_valid), 64'h1);
      check("t6_data", 64'(all_input), 64'(pack(mdl[0], mdl[1], mdl[2], mdl[3])));
      check("t6_err", 64'(err), 64'(exp_err));
      consume("t6");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
